// File: rtl/hood_mode_ctrl_pkg.sv
// Shared types for the range-hood mode controller.
// Holds the state encoding, countdown width and level-width helper.
package hood_pkg;

  typedef enum logic [2:0] {
    S_OFF      = 3'd0,
    S_STANDBY  = 3'd1,
    S_MENU     = 3'd2,
    S_RUN      = 3'd3,
    S_TURBO    = 3'd4,
    S_COOLDOWN = 3'd5
  } state_e;

  localparam int CNT_W = 8;

  // Width of cur_level: levels 0..n.
  function automatic int lvl_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/hood_mode_ctrl_if.sv
// Button/display bundle between the board and the hood controller.
// master: button side (drives buttons); slave: controller (drives outputs).
interface hood_mode_ctrl_if #(
  parameter int NUM_LEVELS = 3
);
  import hood_pkg::*;

  localparam int LW = lvl_w(NUM_LEVELS);

  logic                  on_off_btn;
  logic                  menu_btn;
  logic [NUM_LEVELS-1:0] level_btn;
  logic [2:0]            state_o;
  logic [LW-1:0]         cur_level;
  logic [NUM_LEVELS-1:0] level_led;
  logic [CNT_W-1:0]      countdown;
  logic                  power_led;
  logic                  menu_led;

  modport master (
    output on_off_btn, menu_btn, level_btn,
    input  state_o, cur_level, level_led,
    input  countdown, power_led, menu_led
  );

  modport slave (
    input  on_off_btn, menu_btn, level_btn,
    output state_o, cur_level, level_led,
    output countdown, power_led, menu_led
  );

endinterface

// File: rtl/hood_mode_ctrl_sec_tick_gen.sv
// sec_tick_gen: seconds prescaler, counts 0..TICK_DIV-1.
// Ports: clk, rst (async low), clr_i restarts count, sec_tick_o at wrap.
module sec_tick_gen #(
  parameter int TICK_DIV = 100000000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  output logic sec_tick_o
);

  localparam int W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [W-1:0] cnt_q;

  assign sec_tick_o = (cnt_q == W'(TICK_DIV - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (clr_i || sec_tick_o) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + W'(1);
    end
  end

endmodule

// File: rtl/hood_mode_ctrl.sv
// hood_mode_ctrl: range-hood fan mode FSM with timed turbo/cooldown.
// Ports: clk, rst (async low), io (slave: buttons in, display/LEDs out).
// Optional: TURBO_LOCK_EN allows turbo once per power-on session.
module hood_mode_ctrl
  import hood_pkg::*;
#(
  parameter int NUM_LEVELS       = 3,
  parameter int TICK_DIV         = 100000000,
  parameter int MENU_TIMEOUT_SEC = 10,
  parameter int TURBO_SEC        = 60,
  parameter int COOLDOWN_SEC     = 60
) (
  input logic             clk,
  input logic             rst,
  hood_mode_ctrl_if.slave io
);

  localparam int NL = NUM_LEVELS;
  localparam int LW = lvl_w(NUM_LEVELS);

  state_e           state_q, state_d;
  logic [LW-1:0]    level_q, level_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [NL-1:0]    led_q, led_d;
  logic             pwr_q, mled_q;

  logic             on_q, menu_q;
  logic [NL-1:0]    lvl_q;
  logic             p_on, p_menu;
  logic [NL-1:0]    p_lvl;

  logic             lvl_any, lvl_turbo;
  logic [LW-1:0]    lvl_sel;

  logic             load, tick, expire;
  logic             lock_set;

  assign p_on   = io.on_off_btn & ~on_q;
  assign p_menu = io.menu_btn & ~menu_q;
  assign p_lvl  = io.level_btn & ~lvl_q;

  sec_tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (load),
    .sec_tick_o(tick)
  );

`ifdef TURBO_LOCK_EN
  logic lock_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lock_q <= 1'b0;
    end else if (state_d == S_OFF) begin
      lock_q <= 1'b0;
    end else if (lock_set) begin
      lock_q <= 1'b1;
    end
  end
`else
  logic lock_q;
  logic unused_lock;
  assign lock_q      = 1'b0;
  assign unused_lock = lock_set;
`endif

  // Lowest pressed index wins; scan high to low.
  always_comb begin
    lvl_sel = '0;
    lvl_any = 1'b0;
    for (int i = NL - 1; i >= 0; i--) begin
      if (p_lvl[i]) begin
        lvl_sel = LW'(i + 1);
        lvl_any = 1'b1;
      end
    end
    lvl_turbo = lvl_any && (lvl_sel == LW'(NL));
  end

  always_comb begin
    state_d  = state_q;
    level_d  = level_q;
    timer_d  = timer_q;
    load     = 1'b0;
    lock_set = 1'b0;
    expire   = tick && (timer_q == CNT_W'(1));
    if (tick && (timer_q != '0)) begin
      timer_d = timer_q - CNT_W'(1);
    end
    unique case (state_q)
      S_OFF: begin
        if (p_on) begin
          state_d = S_STANDBY;
        end
      end
      S_STANDBY: begin
        if (p_on) begin
          state_d = S_OFF;
        end else if (p_menu) begin
          state_d = S_MENU;
          timer_d = CNT_W'(MENU_TIMEOUT_SEC);
          load    = 1'b1;
        end
      end
      S_MENU: begin
        if (p_on) begin
          state_d = S_OFF;
          timer_d = '0;
        end else if (p_menu) begin
          state_d = S_STANDBY;
          timer_d = '0;
        end else if (lvl_any && !lvl_turbo) begin
          state_d = S_RUN;
          level_d = lvl_sel;
          timer_d = '0;
        end else if (lvl_turbo && !lock_q) begin
          state_d  = S_TURBO;
          level_d  = LW'(NL);
          timer_d  = CNT_W'(TURBO_SEC);
          load     = 1'b1;
          lock_set = 1'b1;
        end else if (expire) begin
          state_d = S_STANDBY;
        end
      end
      S_RUN: begin
        if (p_on) begin
          state_d = S_OFF;
          level_d = '0;
        end else if (p_menu) begin
          state_d = S_STANDBY;
          level_d = '0;
        end else if (lvl_any && !lvl_turbo) begin
          level_d = lvl_sel;
        end
      end
      S_TURBO: begin
        if (p_menu) begin
          state_d = S_COOLDOWN;
          level_d = LW'(NL);
          timer_d = CNT_W'(COOLDOWN_SEC);
          load    = 1'b1;
        end else if (expire) begin
          state_d = S_RUN;
          level_d = LW'(NL - 1);
        end
      end
      S_COOLDOWN: begin
        if (expire) begin
          state_d = S_STANDBY;
          level_d = '0;
        end
      end
      default: begin
        state_d = S_OFF;
        level_d = '0;
        timer_d = '0;
      end
    endcase
  end

  always_comb begin
    led_d = '0;
    for (int i = 0; i < NL; i++) begin
      led_d[i] = (level_d == LW'(i + 1));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_OFF;
      level_q <= '0;
      timer_q <= '0;
      led_q   <= '0;
      pwr_q   <= 1'b0;
      mled_q  <= 1'b0;
      on_q    <= 1'b0;
      menu_q  <= 1'b0;
      lvl_q   <= '0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      timer_q <= timer_d;
      led_q   <= led_d;
      pwr_q   <= (state_d != S_OFF);
      mled_q  <= (state_d == S_MENU);
      on_q    <= io.on_off_btn;
      menu_q  <= io.menu_btn;
      lvl_q   <= io.level_btn;
    end
  end

  assign io.state_o   = state_q;
  assign io.cur_level = level_q;
  assign io.level_led = led_q;
  assign io.countdown = timer_q;
  assign io.power_led = pwr_q;
  assign io.menu_led  = mled_q;

endmodule

// File: tb/tb_hood_mode_ctrl.sv
// Self-checking bench for hood_mode_ctrl.
// Scoreboard of expected outputs, compared one cycle after stimulus.
module tb_hood_mode_ctrl;

  localparam int OFF = 0;
  localparam int SB  = 1;
  localparam int MN  = 2;
  localparam int RN  = 3;
  localparam int TU  = 4;
  localparam int CD  = 5;

  typedef struct {
    string tag;
    int    st;
    int    lvl;
    int    cd;
  } exp_t;

  logic clk;
  logic rst;
  int   errors;
  int   checks;
  exp_t sbq[$];

  hood_mode_ctrl_if #(.NUM_LEVELS(3)) hif ();

  hood_mode_ctrl #(
    .NUM_LEVELS      (3),
    .TICK_DIV        (4),
    .MENU_TIMEOUT_SEC(3),
    .TURBO_SEC       (2),
    .COOLDOWN_SEC    (2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .io (hif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: sim time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag,
                       input int unsigned act,
                       input int unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic expect_next(input string tag,
                             input int st,
                             input int lvl,
                             input int cd);
    exp_t e;
    e.tag = tag;
    e.st  = st;
    e.lvl = lvl;
    e.cd  = cd;
    sbq.push_back(e);
  endtask

  task automatic step();
    exp_t e;
    int   led;
    @(posedge clk);
    #1;
    if (sbq.size() > 0) begin
      e   = sbq.pop_front();
      led = (e.lvl == 0) ? 0 : (1 << (e.lvl - 1));
      check({e.tag, ".state"}, hif.state_o, e.st);
      check({e.tag, ".level"}, hif.cur_level, e.lvl);
      check({e.tag, ".led"}, hif.level_led, led);
      check({e.tag, ".cd"}, hif.countdown, e.cd);
      check({e.tag, ".pwr"}, hif.power_led, (e.st != OFF) ? 1 : 0);
      check({e.tag, ".mled"}, hif.menu_led, (e.st == MN) ? 1 : 0);
    end
  endtask

  task automatic act(input string tag,
                     input logic on,
                     input logic mn,
                     input logic [2:0] lv,
                     input int st,
                     input int lvl,
                     input int cd);
    hif.on_off_btn = on;
    hif.menu_btn   = mn;
    hif.level_btn  = lv;
    expect_next(tag, st, lvl, cd);
    step();
    hif.on_off_btn = 1'b0;
    hif.menu_btn   = 1'b0;
    hif.level_btn  = 3'b000;
    step();
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b0;
    hif.on_off_btn = 1'b0;
    hif.menu_btn   = 1'b0;
    hif.level_btn  = 3'b000;
    expect_next("reset", OFF, 0, 0);
    step();
    step();
    rst = 1'b1;
    step();

    act("pwr_on", 1, 0, 3'b000, SB, 0, 0);
    act("pwr_off", 1, 0, 3'b000, OFF, 0, 0);
    act("off_ign", 0, 1, 3'b001, OFF, 0, 0);
    act("pwr_on2", 1, 0, 3'b000, SB, 0, 0);
    act("sb_lvl_ign", 0, 0, 3'b001, SB, 0, 0);
    act("prio_on", 1, 1, 3'b000, OFF, 0, 0);
    act("pwr_on3", 1, 0, 3'b000, SB, 0, 0);

    act("menu_in", 0, 1, 3'b000, MN, 0, 3);
    step();
    step();
    expect_next("menu_t2", MN, 0, 2);
    step();
    repeat (6) step();
    expect_next("menu_t1", MN, 0, 1);
    step();
    expect_next("menu_tout", SB, 0, 0);
    step();

    act("menu_in2", 0, 1, 3'b000, MN, 0, 3);
    act("sel_low", 0, 0, 3'b011, RN, 1, 0);
    act("sel_2", 0, 0, 3'b010, RN, 2, 0);
    act("run_turbo_ign", 0, 0, 3'b100, RN, 2, 0);
    act("run_menu", 0, 1, 3'b000, SB, 0, 0);

    act("menu_in3", 0, 1, 3'b000, MN, 0, 3);
    repeat (10) step();
    act("btn_beats_exp", 0, 0, 3'b001, RN, 1, 0);
    act("run_menu2", 0, 1, 3'b000, SB, 0, 0);

    act("menu_in4", 0, 1, 3'b000, MN, 0, 3);
    act("turbo_in", 0, 0, 3'b100, TU, 3, 2);
    step();
    step();
    expect_next("turbo_t1", TU, 3, 1);
    step();
    repeat (3) step();
    expect_next("turbo_exp", RN, 2, 0);
    step();

    act("run_menu3", 0, 1, 3'b000, SB, 0, 0);
    act("cyc_off", 1, 0, 3'b000, OFF, 0, 0);
    act("cyc_on", 1, 0, 3'b000, SB, 0, 0);
    act("menu_in5", 0, 1, 3'b000, MN, 0, 3);
    act("turbo_in2", 0, 0, 3'b100, TU, 3, 2);
    act("turbo_on_ign", 1, 0, 3'b000, TU, 3, 2);
    act("cool_in", 0, 1, 3'b000, CD, 3, 2);
    act("cool_lvl_ign", 0, 0, 3'b001, CD, 3, 2);
    act("cool_on_ign", 1, 0, 3'b000, CD, 3, 1);
    step();
    step();
    expect_next("cool_exp", SB, 0, 0);
    step();

`ifdef TURBO_LOCK_EN
    act("lock_menu", 0, 1, 3'b000, MN, 0, 3);
    act("lock_ign", 0, 0, 3'b100, MN, 0, 3);
    act("lock_back", 0, 1, 3'b000, SB, 0, 0);
    act("lock_off", 1, 0, 3'b000, OFF, 0, 0);
    act("lock_on", 1, 0, 3'b000, SB, 0, 0);
    act("lock_menu2", 0, 1, 3'b000, MN, 0, 3);
    act("lock_clr", 0, 0, 3'b100, TU, 3, 2);
`else
    act("re_menu", 0, 1, 3'b000, MN, 0, 3);
    act("re_turbo", 0, 0, 3'b100, TU, 3, 2);
`endif

    rst = 1'b0;
    expect_next("rst_turbo", OFF, 0, 0);
    step();
    rst = 1'b1;
    step();
    act("post_rst_on", 1, 0, 3'b000, SB, 0, 0);

    if (sbq.size() != 0) begin
      check("sb_drain", sbq.size(), 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hood_mode_ctrl.md
Name: hood_mode_ctrl

Overview:
- Parametrised range-hood mode controller. Successor to the fixed three-level smoker mode logic.
- Supports NUM_LEVELS fan levels; the highest level is a timed turbo ("hurricane") mode.
- Adds a menu idle timeout and a timed cooldown exit from turbo, both driven by an internal seconds prescaler.
- Sits between the debounced board buttons and the display/LED drivers; its outputs feed the 7-seg driver and the LEDs.

Parameters:
- NUM_LEVELS, 3, number of fan levels including turbo; must be >= 2.
- TICK_DIV, 100000000, clk cycles per one-second tick (tests use 4).
- MENU_TIMEOUT_SEC, 10, seconds of menu inactivity before returning to standby; range 1..255.
- TURBO_SEC, 60, turbo run time before automatic step-down; range 1..255.
- COOLDOWN_SEC, 60, run-on time after turbo is cancelled; range 1..255.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-low reset.
- on_off_btn  in  1  debounced power button, level.
- menu_btn  in  1  debounced menu button, level.
- level_btn  in  NUM_LEVELS  debounced level buttons; bit i selects level i+1.
- state_o  out  3  encoded state: OFF=0, STANDBY=1, MENU=2, RUN=3, TURBO=4, COOLDOWN=5.
- cur_level  out  $clog2(NUM_LEVELS+1)  active fan level; 0 means none.
- level_led  out  NUM_LEVELS  one-hot copy of cur_level; all zero when cur_level is 0.
- countdown  out  8  remaining seconds in MENU, TURBO and COOLDOWN; 0 in all other states.
- power_led  out  1  high in every state except OFF.
- menu_led  out  1  high only in MENU.

Behaviour:
- Reset (async assert, sync release):
  - state OFF; all outputs 0; edge registers, prescaler, timer and turbo lock cleared.
- Edge detect:
  - Each button is registered; a press is a 0->1 transition only.
  - Press sampled at cycle n (input was low at n-1): the resulting state and outputs are visible at n+1.
  - Held buttons never re-trigger.
- Priority within one cycle: on_off > menu > level. Among level buttons, the lowest index wins.
- Prescaler:
  - Counts 0..TICK_DIV-1 and emits a 1-cycle sec_tick at the wrap.
  - Cleared whenever the timer is loaded, so the first decrement lands exactly TICK_DIV cycles after the load.
  - The timer decrements on sec_tick while it is nonzero.
- OFF: on_off press -> STANDBY. All other inputs are ignored.
- STANDBY:
  - on_off -> OFF.
  - menu -> MENU, timer loaded with MENU_TIMEOUT_SEC.
  - Level buttons are ignored.
- MENU:
  - on_off -> OFF.
  - menu -> STANDBY.
  - level_btn[i], i < NUM_LEVELS-1 -> RUN with cur_level = i+1.
  - level_btn[NUM_LEVELS-1] -> TURBO with cur_level = NUM_LEVELS, timer = TURBO_SEC.
  - Timer reaching 0 -> STANDBY.
- RUN:
  - on_off -> OFF.
  - menu -> STANDBY.
  - A non-turbo level press changes cur_level directly; the state stays RUN.
  - A turbo press is ignored; turbo is entered only via MENU.
- TURBO:
  - on_off and level buttons are ignored (safety).
  - menu -> COOLDOWN, cur_level = NUM_LEVELS, timer = COOLDOWN_SEC.
  - Timer reaching 0 -> RUN at cur_level = NUM_LEVELS-1.
- COOLDOWN:
  - All buttons are ignored; the fan stays at turbo level.
  - Timer reaching 0 -> STANDBY, cur_level = 0.
- A timer expiry and a button press in the same cycle: the button wins.
- Reset mid-turbo or mid-cooldown goes immediately to OFF, no run-on.

Optional Feature:
- TURBO_LOCK_EN defined:
  - Turbo may be entered once per power-on session.
  - A lock flag is set on TURBO entry and cleared in OFF and on reset.
  - While the flag is set, a turbo press in MENU is ignored and the state stays MENU; the menu timer keeps running.
- Not defined: turbo can be entered any number of times.

Decomposition:
- Package hood_pkg holds:
  - state encoding constants;
  - countdown width 8;
  - the level-width function.
- One sub-module, sec_tick_gen (prescaler with clear input, emits sec_tick); instantiated once.

Test Plan:
- Power toggle: reset, on_off pulse -> state_o=1 and power_led=1 the next cycle; second pulse -> state_o=0 and all outputs 0.
- Menu timeout (TICK_DIV=4, MENU_TIMEOUT_SEC=3): STANDBY, menu pulse -> countdown=3, menu_led=1; 12 cycles later -> state_o=1, countdown=0.
- Level select (NUM_LEVELS=3):
  - MENU, level_btn=3'b011 -> RUN, cur_level=1, level_led=3'b001.
  - Then level_btn[1] -> cur_level=2.
- Turbo expiry (TURBO_SEC=2, TICK_DIV=4): MENU, level_btn[2] -> TURBO, countdown=2; 8 cycles later -> RUN, cur_level=2.
- Turbo cancel (COOLDOWN_SEC=2):
  - In TURBO, an on_off press has no effect.
  - menu -> COOLDOWN, countdown=2, cur_level=3.
  - Button presses are ignored; after 8 cycles -> STANDBY, cur_level=0.
- TURBO_LOCK_EN:
  - After one turbo cycle, re-enter MENU and press turbo -> state stays MENU.
  - Power off/on, then turbo press -> TURBO.
